// File: rtl/data_mem_backend.sv
// -----------------------------------------------------------------------------
// data_mem_backend
//
// Line-granular backing store placed directly behind the processor data cache.
// Fills are returned as LINE_WORDS gap-free beats after a fixed RD_LATENCY
// wait. Write-backs are accepted one beat per valid cycle, and gaps are allowed.
// All storage is one block RAM addressed as {line, beat}.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  cache presents a line request
//   req_ready  high only in IDLE; accept on req_valid & req_ready
//   req_write  1 = write-back, 0 = fill (sampled at accept)
//   req_line   line index (sampled at accept)
//   wr_data    write-back beat data
//   wr_valid   write-back beat present
//   wr_ready   high throughout WRITE
//   rd_data    fill beat data (holds when rd_valid is low)
//   rd_valid   fill beat valid, no backpressure
//   rd_last    final fill beat
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module data_mem_backend #(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WORDS = 4,
    parameter int RD_LATENCY = 2,
    localparam int LW        = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-LW-1:0] req_line,
    input  logic [31:0]              wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     done
);

    localparam int LINE_W = ADDR_WIDTH - LW;
    localparam int CW     = $clog2(RD_LATENCY + 1);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [LW-1:0] LAST_BEAT = LW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Storage (never reset)
    logic [31:0] mem [DEPTH];

    // Control state
    state_t            state_r;
    state_t            next_state_s;
    logic [LINE_W-1:0] line_r;
    logic [LINE_W-1:0] line_s;
    logic [LW-1:0]     k_r;
    logic [LW-1:0]     k_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_s;

    // BRAM port controls
    logic                  rd_en_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;

    // Registered outputs
    logic        req_ready_r;
    logic        wr_ready_r;
    logic [31:0] rd_data_r;
    logic        rd_valid_r;
    logic        rd_last_r;
    logic        busy_r;
    logic        done_r;

    // The beat index occupies the low bits, so it can never carry into the line.
    assign mem_addr_s = {line_r, k_r};

    // Next-state, beat counter and BRAM enables
    always_comb begin
        next_state_s = state_r;
        line_s       = line_r;
        k_s          = k_r;
        cnt_s        = cnt_r;
        rd_en_s      = 1'b0;
        mem_we_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    line_s = req_line;
                    k_s    = {LW{1'b0}};
                    if (req_write) begin
                        next_state_s = S_WRITE;
                        cnt_s        = {CW{1'b0}};
                    end else begin
                        next_state_s = S_WAIT;
                        cnt_s        = CW'(RD_LATENCY);
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end

            S_WAIT: begin
                // Beat 0 is read on the last WAIT edge so that it is already
                // registered on rd_data in the first READ cycle.
                if (cnt_r <= CW'(1)) begin
                    next_state_s = S_READ;
                    rd_en_s      = 1'b1;
                    k_s          = k_r + LW'(1);
                    cnt_s        = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end

            S_READ: begin
                // Each READ edge fetches the next beat one cycle ahead. The last
                // beat is on the bus while rd_last_r is high.
                if (rd_last_r) begin
                    next_state_s = S_DONE;
                end else begin
                    rd_en_s = 1'b1;
                    k_s     = k_r + LW'(1);
                end
            end

            S_WRITE: begin
                if (wr_valid) begin
                    mem_we_s = 1'b1;
                    k_s      = k_r + LW'(1);
                    if (k_r == LAST_BEAT) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_WRITE;
                    end
                end else begin
                    next_state_s = S_WRITE;
                end
            end

            S_DONE: begin
                next_state_s = S_IDLE;
            end

            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, line/beat/latency registers and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            line_r      <= {LINE_W{1'b0}};
            k_r         <= {LW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            req_ready_r <= 1'b1;
            wr_ready_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            line_r      <= line_s;
            k_r         <= k_s;
            cnt_r       <= cnt_s;
            // Outputs are decodes of the next state, registered so that they
            // match the state decode cycle for cycle without combinational paths.
            req_ready_r <= (next_state_s == S_IDLE);
            busy_r      <= (next_state_s != S_IDLE);
            wr_ready_r  <= (next_state_s == S_WRITE);
            done_r      <= (next_state_s == S_DONE);
            rd_valid_r  <= rd_en_s;
            rd_last_r   <= rd_en_s && (k_r == LAST_BEAT);
        end
    end

    // BRAM write port. A beat on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem[mem_addr_s] <= wr_data;
        end
    end

    // BRAM read port with a resettable output register that holds between beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= 32'd0;
        end else if (rd_en_s) begin
            rd_data_r <= mem[mem_addr_s];
        end
    end

    assign req_ready = req_ready_r;
    assign wr_ready  = wr_ready_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign rd_last   = rd_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
